// File: rtl/pipe_ctrl.sv
// Pipeline controller: per-stage stall/flush, branch redirect, single-level interrupt with EPC, stall counter.
// Latency: stall/flush/redirect/ack are combinational from inputs and state; EPC, ISR flag and counter update on the clock edge.
// Backpressure: the highest requesting stage holds every stage below it; redirects and interrupt takes wait while their stage is held.
module pipe_ctrl #(
    parameter int          STAGES    = 5,
    parameter int          AW        = 32,
    parameter int          BR_STAGE  = 1,
    parameter int          INT_STAGE = 2,
    parameter logic [31:0] INT_VEC   = 32'h8000_0004,
    parameter int          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stall_req_i,
    input  logic              br_taken_i,
    input  logic [AW-1:0]     br_addr_i,
    input  logic              int_req_i,
    input  logic              int_en_i,
    input  logic              eret_i,
    input  logic [AW-1:0]     epc_pc_i,
    input  logic              clr_cnt_i,
    output logic [STAGES-1:0] stall_o,
    output logic [STAGES-1:0] flush_o,
    output logic              redirect_o,
    output logic [AW-1:0]     redirect_addr_o,
    output logic              int_ack_o,
    output logic              in_isr_o,
    output logic [AW-1:0]     epc_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [STAGES-1:0] BR_MASK   = STAGES'((1 << BR_STAGE) - 1);
    localparam logic [STAGES-1:0] INT_MASK  = STAGES'((1 << INT_STAGE) - 1);
    localparam logic [AW-1:0]     INT_VEC_A = AW'(INT_VEC);

    typedef enum logic [1:0] {IDLE, PEND, ISR} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     epc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [STAGES-1:0] req_stall;
    logic              br_vld;
    logic              take;
    logic              ret;

    // A stage is held when it or any later stage requests a stall.
    always_comb begin
        req_stall = '0;
        for (int i = 0; i < STAGES; i++) begin
            req_stall[i] = |(stall_req_i >> i);
        end
    end

    always_comb begin
        state_d         = state_q;
        stall_o         = '0;
        flush_o         = '0;
        redirect_o      = 1'b0;
        redirect_addr_o = '0;
        int_ack_o       = 1'b0;
        br_vld          = 1'b0;
        take            = 1'b0;
        ret             = 1'b0;
        if (rst) begin
            stall_o = req_stall;
            br_vld  = br_taken_i & ~req_stall[BR_STAGE];
            take    = (state_q == PEND) & ~req_stall[INT_STAGE] & ~br_vld & int_en_i;
            ret     = (state_q == ISR) & eret_i & ~req_stall[INT_STAGE] & ~br_vld;

            if (br_vld) begin
                stall_o         = stall_o & ~BR_MASK;
                redirect_o      = 1'b1;
                redirect_addr_o = br_addr_i;
            end else if (take) begin
                stall_o         = stall_o & ~INT_MASK;
                redirect_o      = 1'b1;
                redirect_addr_o = INT_VEC_A;
                int_ack_o       = 1'b1;
            end else if (ret) begin
                stall_o         = stall_o & ~INT_MASK;
                redirect_o      = 1'b1;
                redirect_addr_o = epc_q;
            end

            // Bubble goes into the first stage after the held block.
            for (int i = 1; i < STAGES; i++) begin
                flush_o[i] = stall_o[i-1] & ~stall_o[i];
            end
            if (br_vld) begin
                flush_o = flush_o | BR_MASK;
            end else if (take || ret) begin
                flush_o = flush_o | INT_MASK;
            end

            case (state_q)
                IDLE:    if (int_req_i && int_en_i) state_d = PEND;
                PEND:    if (take) state_d = ISR;
                ISR:     if (ret) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            epc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                epc_q <= epc_pc_i;
            end
            if (clr_cnt_i) begin
                cnt_q <= '0;
            end else if (stall_o[0] && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign in_isr_o    = (state_q == ISR);
    assign epc_o       = epc_q;
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: per-cycle comparison against a rule-level model plus literal spot checks.
module tb_pipe_ctrl;

    localparam int STAGES    = 5;
    localparam int BR_STAGE  = 1;
    localparam int INT_STAGE = 2;
    localparam int CNT_W     = 6;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;
    localparam logic [31:0] INT_VEC = 32'h8000_0004;

    logic              clk = 1'b0;
    logic              rst;
    logic [STAGES-1:0] stall_req;
    logic              br_taken;
    logic [31:0]       br_addr;
    logic              int_req;
    logic              int_en;
    logic              eret;
    logic [31:0]       epc_pc;
    logic              clr_cnt;
    logic [STAGES-1:0] stall_o;
    logic [STAGES-1:0] flush_o;
    logic              redirect_o;
    logic [31:0]       redirect_addr_o;
    logic              int_ack_o;
    logic              in_isr_o;
    logic [31:0]       epc_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    pipe_ctrl #(
        .STAGES(STAGES), .AW(32), .BR_STAGE(BR_STAGE), .INT_STAGE(INT_STAGE),
        .INT_VEC(INT_VEC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .stall_req_i(stall_req), .br_taken_i(br_taken),
        .br_addr_i(br_addr), .int_req_i(int_req), .int_en_i(int_en), .eret_i(eret),
        .epc_pc_i(epc_pc), .clr_cnt_i(clr_cnt), .stall_o(stall_o), .flush_o(flush_o),
        .redirect_o(redirect_o), .redirect_addr_o(redirect_addr_o), .int_ack_o(int_ack_o),
        .in_isr_o(in_isr_o), .epc_o(epc_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: interrupt pending / handler running flags, saved PC, counter as an integer.
    logic        m_pend = 1'b0;
    logic        m_isr  = 1'b0;
    logic [31:0] m_epc  = '0;
    int          m_cnt  = 0;

    logic [STAGES-1:0] e_stall, e_flush;
    logic              e_redir, e_ack, e_take, e_ret, br_v;
    logic [31:0]       e_addr;
    int                k;

    always_comb begin
        e_stall = '0;
        e_flush = '0;
        e_redir = 1'b0;
        e_addr  = '0;
        e_ack   = 1'b0;
        e_take  = 1'b0;
        e_ret   = 1'b0;
        br_v    = 1'b0;
        k       = -1;
        if (rst) begin
            for (int i = 0; i < STAGES; i++) if (stall_req[i]) k = i;
            for (int i = 0; i < STAGES; i++) e_stall[i] = (i <= k);
            if (k >= 0 && k < STAGES - 1) e_flush[k+1] = 1'b1;
            br_v   = br_taken && (k < BR_STAGE);
            e_take = m_pend && (k < INT_STAGE) && !br_v && int_en;
            e_ret  = m_isr && eret && (k < INT_STAGE) && !br_v;
            // Every requested stage lies below the redirecting one, so the whole stall disappears.
            if (br_v) begin
                e_stall = '0;
                e_flush = STAGES'((1 << BR_STAGE) - 1);
                e_redir = 1'b1;
                e_addr  = br_addr;
            end else if (e_take || e_ret) begin
                e_stall = '0;
                e_flush = STAGES'((1 << INT_STAGE) - 1);
                e_redir = 1'b1;
                e_addr  = e_take ? INT_VEC : m_epc;
                e_ack   = e_take;
            end
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pend <= 1'b0;
            m_isr  <= 1'b0;
            m_epc  <= '0;
            m_cnt  <= 0;
        end else begin
            if (e_take) begin
                m_pend <= 1'b0;
                m_isr  <= 1'b1;
                m_epc  <= epc_pc;
            end else if (e_ret) begin
                m_isr <= 1'b0;
            end else if (!m_pend && !m_isr && int_req && int_en) begin
                m_pend <= 1'b1;
            end
            if (clr_cnt) m_cnt <= 0;
            else if (e_stall[0] && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        check("cmp_stall", stall_o, e_stall);
        check("cmp_flush", flush_o, e_flush);
        check("cmp_redir", redirect_o, e_redir);
        if (e_redir) check("cmp_addr", redirect_addr_o, e_addr);
        check("cmp_ack", int_ack_o, e_ack);
        check("cmp_isr", in_isr_o, m_isr);
        check("cmp_epc", epc_o, m_epc);
        check("cmp_cnt", stall_cnt_o, 64'(m_cnt));
    end

    task automatic idle_inputs();
        stall_req = '0;
        br_taken  = 1'b0;
        br_addr   = '0;
        int_req   = 1'b0;
        int_en    = 1'b0;
        eret      = 1'b0;
        epc_pc    = '0;
        clr_cnt   = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        stall_req = 5'b11111;
        br_taken  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", stall_o, 0);
        check("rst_redir", redirect_o, 0);
        check("rst_cnt", stall_cnt_o, 0);
        check("rst_isr", in_isr_o, 0);
        check("rst_epc", epc_o, 0);

        // EX stall for three cycles
        next();
        idle_inputs();
        rst = 1'b1;
        stall_req = 5'b00100;
        @(negedge clk);
        check("ex_stall", stall_o, 5'b00111);
        check("ex_flush", flush_o, 5'b01000);
        repeat (3) next();
        stall_req = '0;
        check("cnt3", stall_cnt_o, 3);

        // branch beats IF stall, but not ID stall
        br_taken = 1'b1;
        br_addr = 32'h100;
        stall_req = 5'b00001;
        @(negedge clk);
        check("br_redir", redirect_o, 1);
        check("br_addr", redirect_addr_o, 32'h100);
        check("br_flush", flush_o, 5'b00001);
        check("br_stall", stall_o, 0);
        next();
        stall_req = 5'b00010;
        @(negedge clk);
        check("brblk_redir", redirect_o, 0);
        check("brblk_stall", stall_o, 5'b00011);
        check("brblk_flush", flush_o, 5'b00100);
        next();
        idle_inputs();

        // interrupt pulse during a two-cycle EX stall
        int_en = 1'b1;
        int_req = 1'b1;
        stall_req = 5'b00100;
        epc_pc = 32'h40;
        @(negedge clk);
        check("int_noack0", int_ack_o, 0);
        next();
        int_req = 1'b0;
        @(negedge clk);
        check("int_noack1", int_ack_o, 0);
        next();
        stall_req = '0;
        @(negedge clk);
        check("take_ack", int_ack_o, 1);
        check("take_redir", redirect_o, 1);
        check("take_addr", redirect_addr_o, 32'h8000_0004);
        check("take_flush", flush_o, 5'b00011);
        next();
        epc_pc = 32'h99;
        @(negedge clk);
        check("isr_flag", in_isr_o, 1);
        check("isr_epc", epc_o, 32'h40);
        check("isr_ack0", int_ack_o, 0);

        // no nesting, then ERET, then ERET outside the handler
        next();
        int_req = 1'b1;
        @(negedge clk);
        check("nest_ack", int_ack_o, 0);
        next();
        int_req = 1'b0;
        eret = 1'b1;
        @(negedge clk);
        check("eret_redir", redirect_o, 1);
        check("eret_addr", redirect_addr_o, 32'h40);
        check("eret_flush", flush_o, 5'b00011);
        next();
        @(negedge clk);
        check("post_eret_isr", in_isr_o, 0);
        check("idle_eret_redir", redirect_o, 0);
        next();
        eret = 1'b0;

        // reset while in the handler
        int_req = 1'b1;
        epc_pc = 32'h80;
        next();
        int_req = 1'b0;
        @(negedge clk);
        check("take2_ack", int_ack_o, 1);
        next();
        @(negedge clk);
        check("take2_isr", in_isr_o, 1);
        check("take2_epc", epc_o, 32'h80);
        #2 rst = 1'b0;
        #1;
        check("arst_isr", in_isr_o, 0);
        check("arst_epc", epc_o, 0);
        next();
        rst = 1'b1;

        // reset while pending with interrupts disabled drops the request
        int_en = 1'b1;
        int_req = 1'b1;
        next();
        int_req = 1'b0;
        int_en = 1'b0;
        @(negedge clk);
        check("pend_wait_ack", int_ack_o, 0);
        #2 rst = 1'b0;
        next();
        rst = 1'b1;
        int_en = 1'b1;
        @(negedge clk);
        check("pend_lost_ack", int_ack_o, 0);
        next();
        @(negedge clk);
        check("pend_lost_isr", in_isr_o, 0);
        idle_inputs();

        // WB stall: everything held, no bubble
        stall_req = 5'b10000;
        @(negedge clk);
        check("wb_stall", stall_o, 5'b11111);
        check("wb_flush", flush_o, 0);

        // counter saturation and clear-over-increment
        next();
        clr_cnt = 1'b1;
        next();
        clr_cnt = 1'b0;
        stall_req = 5'b00001;
        repeat (CNT_MAX + 8) next();
        check("cnt_sat", stall_cnt_o, CNT_MAX);
        clr_cnt = 1'b1;
        next();
        check("cnt_clr", stall_cnt_o, 0);
        idle_inputs();
        repeat (2) next();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
